// File: rtl/trap_controller.sv
// Trap sequencer between the status register and the control unit: detects enabled
// fault flags and walks ENTER -> SAVE -> HANDLER -> RETURN, with a handler watchdog.
module trap_controller #(
    parameter logic [11:0] VECTOR_BASE = 12'hF00,
    parameter int          TIMEOUT_W   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] statusReg,
    input  logic [4:0]  trap_enable,
    input  logic        handler_done,
    input  logic        xor_req,
    output logic        trap,
    output logic        reg_to_instruction,
    output logic        xorData,
    output logic [2:0]  trap_cause,
    output logic [11:0] trap_vector,
    output logic        trap_overrun,
    output logic [3:0]  overrun_count,
    output logic        timeout
);

    typedef enum logic [2:0] {S_IDLE, S_ENTER, S_SAVE, S_HANDLER, S_RETURN} state_t;

    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    state_t               r_state;
    logic [TIMEOUT_W-1:0] r_wdog;

    logic [4:0]  w_qual;
    logic [2:0]  w_cause;
    logic [4:0]  w_cause_mask;
    logic [11:0] w_vec;
    logic        w_other;
    logic        w_active;
    logic        w_unused_sr;

    // w_qual bit i corresponds to cause code i+1
    assign w_qual = {statusReg[12] & trap_enable[4],
                     statusReg[11] & trap_enable[3],
                     statusReg[18] & trap_enable[2],
                     statusReg[17] & trap_enable[1],
                     statusReg[14] & trap_enable[0]};

    assign w_unused_sr = ^{statusReg[16:15], statusReg[13], statusReg[10:0]};

    always_comb begin
        w_cause = 3'd0;
        if (w_qual[0])      w_cause = 3'd1;
        else if (w_qual[1]) w_cause = 3'd2;
        else if (w_qual[2]) w_cause = 3'd3;
        else if (w_qual[3]) w_cause = 3'd4;
        else if (w_qual[4]) w_cause = 3'd5;
    end

    always_comb begin
        w_cause_mask = 5'b00000;
        case (trap_cause)
            3'd1:    w_cause_mask = 5'b00001;
            3'd2:    w_cause_mask = 5'b00010;
            3'd3:    w_cause_mask = 5'b00100;
            3'd4:    w_cause_mask = 5'b01000;
            3'd5:    w_cause_mask = 5'b10000;
            default: w_cause_mask = 5'b00000;
        endcase
    end

    assign w_vec    = VECTOR_BASE + {7'd0, w_cause, 2'b00};
    assign w_active = (r_state == S_ENTER) || (r_state == S_SAVE) || (r_state == S_HANDLER);
    // The cause currently being serviced is never an overrun of itself
    assign w_other  = |(w_qual & ~w_cause_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_wdog             <= '0;
            trap               <= 1'b0;
            reg_to_instruction <= 1'b0;
            xorData            <= 1'b0;
            trap_cause         <= 3'd0;
            trap_vector        <= 12'h000;
            trap_overrun       <= 1'b0;
            overrun_count      <= 4'd0;
            timeout            <= 1'b0;
        end else begin
            reg_to_instruction <= 1'b0;
            xorData            <= 1'b0;
            timeout            <= 1'b0;

            if (w_active && w_other) begin
                trap_overrun <= 1'b1;
                if (overrun_count != 4'hF) overrun_count <= overrun_count + 4'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (|w_qual) begin
                        trap_cause  <= w_cause;
                        trap_vector <= w_vec;
                        trap        <= 1'b1;
                        r_wdog      <= '0;
                        r_state     <= S_ENTER;
                    end
                end
                S_ENTER: begin
                    reg_to_instruction <= 1'b1;
                    r_state            <= S_SAVE;
                end
                S_SAVE: r_state <= S_HANDLER;
                S_HANDLER: begin
                    if (handler_done) begin
                        trap    <= 1'b0;
                        r_state <= S_RETURN;
                    end else if (r_wdog == WD_MAX) begin
                        trap    <= 1'b0;
                        timeout <= 1'b1;
                        r_state <= S_RETURN;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (xor_req && statusReg[19]) xorData <= 1'b1;
                    end
                end
                S_RETURN: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller (TIMEOUT_W = 3): entry, priority, xor strobe,
// watchdog, overrun saturation and asynchronous reset.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] statusReg;
    logic [4:0]  trap_enable;
    logic        handler_done;
    logic        xor_req;
    logic        trap, reg_to_instruction, xorData, trap_overrun, timeout;
    logic [2:0]  trap_cause;
    logic [11:0] trap_vector;
    logic [3:0]  overrun_count;

    int errs   = 0;
    int checks = 0;
    int k;

    trap_controller #(.VECTOR_BASE(12'hF00), .TIMEOUT_W(3)) dut (
        .clk(clk), .reset(reset), .statusReg(statusReg), .trap_enable(trap_enable),
        .handler_done(handler_done), .xor_req(xor_req), .trap(trap),
        .reg_to_instruction(reg_to_instruction), .xorData(xorData),
        .trap_cause(trap_cause), .trap_vector(trap_vector), .trap_overrun(trap_overrun),
        .overrun_count(overrun_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trap"}, {31'd0, trap}, 0);
        chk({tag, "_rti"}, {31'd0, reg_to_instruction}, 0);
        chk({tag, "_xor"}, {31'd0, xorData}, 0);
        chk({tag, "_cause"}, {29'd0, trap_cause}, 0);
        chk({tag, "_vec"}, {20'd0, trap_vector}, 0);
        chk({tag, "_ovr"}, {31'd0, trap_overrun}, 0);
        chk({tag, "_ovrcnt"}, {28'd0, overrun_count}, 0);
        chk({tag, "_tmo"}, {31'd0, timeout}, 0);
    endtask

    initial begin
        reset = 1'b0; statusReg = '0; trap_enable = '0; handler_done = 1'b0; xor_req = 1'b0;
        step(); step();
        chk_all_zero("reset");
        reset = 1'b1;
        step();

        // div0 trap: entry, one-cycle save strobe, xor strobe handling
        statusReg = 20'h0; statusReg[14] = 1'b1; trap_enable = 5'h1F;
        step();
        chk("div0_trap", {31'd0, trap}, 1);
        chk("div0_cause", {29'd0, trap_cause}, 1);
        chk("div0_vec", {20'd0, trap_vector}, 32'hF04);
        chk("enter_rti", {31'd0, reg_to_instruction}, 0);
        statusReg = 20'h0;
        step();
        chk("save_rti", {31'd0, reg_to_instruction}, 1);
        chk("save_trap", {31'd0, trap}, 1);
        step();
        chk("hdl_rti", {31'd0, reg_to_instruction}, 0);
        statusReg[19] = 1'b1; xor_req = 1'b1;
        step();
        chk("xor_pulse", {31'd0, xorData}, 1);
        chk("xor_trap", {31'd0, trap}, 1);
        xor_req = 1'b0;
        step();
        chk("xor_end", {31'd0, xorData}, 0);
        statusReg[19] = 1'b0; xor_req = 1'b1;
        step();
        chk("xor_nomode", {31'd0, xorData}, 0);
        statusReg[19] = 1'b1; handler_done = 1'b1;
        step();
        chk("done_trap", {31'd0, trap}, 0);
        chk("done_xor", {31'd0, xorData}, 0);
        chk("done_tmo", {31'd0, timeout}, 0);
        handler_done = 1'b0; xor_req = 1'b0; statusReg = 20'h0;
        step();
        step();
        chk("idle_trap", {31'd0, trap}, 0);
        chk("hold_cause", {29'd0, trap_cause}, 1);

        // priority: mem-violate beats overflow
        statusReg[11] = 1'b1; statusReg[17] = 1'b1;
        step();
        chk("mv_cause", {29'd0, trap_cause}, 2);
        chk("mv_vec", {20'd0, trap_vector}, 32'hF08);
        statusReg = 20'h0;
        step(); step();
        handler_done = 1'b1;
        step();
        chk("mv_done_trap", {31'd0, trap}, 0);
        handler_done = 1'b0;
        step();

        // mem-violate disabled -> overflow; then let the watchdog expire
        trap_enable = 5'b01000; statusReg[11] = 1'b1; statusReg[17] = 1'b1;
        step();
        chk("ovf_cause", {29'd0, trap_cause}, 4);
        chk("ovf_vec", {20'd0, trap_vector}, 32'hF10);
        statusReg = 20'h0;
        k = 0;
        while (timeout !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk("tmo_latency", k, 10);
        chk("tmo_trap", {31'd0, trap}, 0);
        step();
        chk("tmo_pulse_end", {31'd0, timeout}, 0);
        step(); step();
        chk("tmo_idle_trap", {31'd0, trap}, 0);
        chk("no_ovr_yet", {31'd0, trap_overrun}, 0);

        // overflow trap with mem-corrupt held: overrun saturates at 15
        trap_enable = 5'h1F; statusReg[11] = 1'b1;
        step();
        chk("ovf2_cause", {29'd0, trap_cause}, 4);
        statusReg[18] = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("ovr_flag", {31'd0, trap_overrun}, 1);
        chk("ovr_sat", {28'd0, overrun_count}, 15);
        chk("retrap_cause", {29'd0, trap_cause}, 3);
        chk("retrap_trap", {31'd0, trap}, 1);

        // asynchronous reset mid-handler
        statusReg = 20'h0; statusReg[19] = 1'b1; xor_req = 1'b1;
        step();
        chk("pre_rst_xor", {31'd0, xorData}, 1);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        xor_req = 1'b0; statusReg = 20'h0;
        step();
        #2 reset = 1'b1;
        step(); step(); step();
        chk("post_rst_trap", {31'd0, trap}, 0);
        chk("post_rst_cause", {29'd0, trap_cause}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
